ascii_uart_tx: RTL and testbench
================================

Name: ascii_uart_tx

Overview:
- Downstream consumer of the binary-to-BCD/ASCII stage.
- Accepts a 32-bit word of four ASCII decimal digits through a ready/valid handshake: the upstream drives bcd_ready, this block drives cross_ready.
- Serialises the digits, thousands first, followed by an optional CR LF, onto a UART 8N1 line.
- Sits between the BCD converter and the board TX pin, and throttles the converter through cross_ready.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- SEND_CRLF, 1, when 1 append 0x0D 0x0A after the four digits; when 0 send digits only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ascii_out  input  32  digit word: [31:24] thousands, [23:16] hundreds, [15:8] tens, [7:0] units.
- bcd_ready  input  1  upstream valid; ascii_out is stable while high.
- cross_ready  output  1  this block can accept a word.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is being transmitted.
- frame_done  output  1  single-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, tx=1, cross_ready=1, busy=0, frame_done=0, all counters and the shift register cleared. Reset asserted mid-frame aborts the frame immediately; tx returns to 1 without completing the byte.
- Handshake: a word is captured on the rising edge where bcd_ready=1 and cross_ready=1.
  - cross_ready=0 from the next cycle until frame_done. It is 1 again in the cycle after the frame_done pulse.
  - bcd_ready while cross_ready=0 is ignored; no queueing.
  - The word is registered at capture, so later changes on ascii_out do not affect the frame.
- Byte order: byte index 0..3 carries ascii_out[31:24], [23:16], [15:8], [7:0]. Indices 4 and 5 carry 0x0D and 0x0A when SEND_CRLF=1.
  - Last index is 5 (SEND_CRLF=1) or 3 (SEND_CRLF=0).
  - Bytes are sent verbatim; no range checking of digit values.
- FSM: IDLE -> START -> DATA -> STOP -> (next byte ? START : DONE) -> IDLE.
  - IDLE: tx=1; on capture go to START, byte index 0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If the byte index is below the last index, increment it and go to START with no idle gap. Otherwise go to DONE.
  - DONE: one cycle; frame_done=1, tx=1; then IDLE.
- Timing:
  - The start bit of byte 0 begins the cycle after capture.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps on the bit boundary.
  - Frame duration from capture to frame_done = N*10*CLKS_PER_BIT cycles, N = 6 or 4. frame_done is asserted in the following cycle.
- busy=1 from the cycle after capture through the DONE cycle inclusive, i.e. whenever the state is not IDLE.
- All outputs are registered; tx never glitches.

Decomposition:
- Package ascii_uart_pkg:
  - state enum (IDLE, START, DATA, STOP, DONE).
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, UART_DATA_BITS=8.
- Sub-module uart_tx_byte: single-byte 8N1 serialiser with start/done handshake, parameterised by CLKS_PER_BIT.
- ascii_uart_tx owns the word capture, byte sequencing and cross_ready.

Test Plan:
1. Basic frame, bench with CLKS_PER_BIT=4, SEND_CRLF=1, ascii_out=0x30323433 ("0243"):
   - capture -> tx decodes 0x30,0x32,0x34,0x33,0x0D,0x0A.
   - frame_done exactly 240 cycles after capture.
   - cross_ready low for the whole frame.
2. Digits only, SEND_CRLF=0, ascii_out=0x30303131 ("0011") -> decoded bytes 0x30,0x30,0x31,0x31; frame_done 160 cycles after capture.
3. Ignore while busy: bcd_ready held 1 and ascii_out changed to 0x39393939 mid-frame -> current frame unchanged. Next capture occurs the cycle cross_ready returns to 1, and the next frame carries 0x39 x4.
4. Reset mid-frame: rst=0 during DATA of byte 2 -> same-instant tx=1, busy=0, cross_ready=1. After release, a new word is captured and sent correctly from byte 0.
5. Bit timing: each start, data and stop bit is held exactly CLKS_PER_BIT cycles. There is no idle cycle between the stop bit of byte k and the start bit of byte k+1.
6. Idle line: no bcd_ready for 100 cycles after reset -> tx=1, busy=0, frame_done never pulses.

Source files
------------

// File: rtl/ascii_uart_pkg.sv
// Shared constants and helpers for the ASCII digit UART transmitter.
package ascii_uart_pkg;

   // Byte-serialiser states
   localparam logic [1:0] BIT_IDLE  = 2'd0;
   localparam logic [1:0] BIT_START = 2'd1;
   localparam logic [1:0] BIT_DATA  = 2'd2;
   localparam logic [1:0] BIT_STOP  = 2'd3;

   // Frame sequencer states (the bit-level START/DATA/STOP phases live in uart_tx_byte)
   localparam logic [1:0] FR_IDLE = 2'd0;
   localparam logic [1:0] FR_SEND = 2'd1;
   localparam logic [1:0] FR_DONE = 2'd2;

   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam int         UART_DATA_BITS = 8;

   // Byte carried at a given frame position: four digits thousands first, then CR LF.
   function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = word[31:24];
         3'd1:    b = word[23:16];
         3'd2:    b = word[15:8];
         3'd3:    b = word[7:0];
         3'd4:    b = ASCII_CR;
         default: b = ASCII_LF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A start request seen during the last stop-bit cycle
// chains the next byte with no idle gap on the line.
module uart_tx_byte
   import ascii_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             bit_end;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   // Last cycle of the stop bit: the moment the next byte may be chained.
   assign byte_done = (state == BIT_STOP) && bit_end;

   // Bit-level state machine; tx is driven from a register so the line never glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= BIT_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state)
            BIT_IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx       <= 1'b1;
               if (start) begin
                  shreg <= data;
                  state <= BIT_START;
                  tx    <= 1'b0;
               end
            end
            BIT_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shreg[0];
                  state    <= BIT_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            BIT_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     tx    <= 1'b1;
                     state <= BIT_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            BIT_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (start) begin
                     shreg <= data;
                     tx    <= 1'b0;
                     state <= BIT_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= BIT_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= BIT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/ascii_uart_tx.sv
// Captures a four-digit ASCII word and sends it (plus optional CR LF) over UART 8N1.
// cross_ready throttles the upstream BCD converter: one word per frame, no queueing.
module ascii_uart_tx
   import ascii_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int SEND_CRLF    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ascii_out,
   input  logic        bcd_ready,
   output logic        cross_ready,
   output logic        tx,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

   logic [1:0]  phase;
   logic [31:0] word_q;
   logic [2:0]  byte_idx;
   logic        capture;
   logic        byte_start;
   logic [7:0]  byte_data;
   logic        byte_done;

   assign capture = bcd_ready && cross_ready;

   // Feed the serialiser: byte 0 straight from the input at capture, later bytes from the held word.
   always_comb begin
      // NOTE: defaults first so no path leaves these unassigned (no latches).
      byte_start = 1'b0;
      byte_data  = 8'h00;
      if (capture) begin
         byte_start = 1'b1;
         byte_data  = ascii_out[31:24];
      end else if ((phase == FR_SEND) && byte_done && (byte_idx != LAST_IDX)) begin
         byte_start = 1'b1;
         byte_data  = frame_byte(word_q, byte_idx + 3'd1);
      end
   end

   // Frame sequencing, handshake and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase       <= FR_IDLE;
         // NOTE: the held word is reset too; it is a handful of flops, not a RAM.
         word_q      <= '0;
         byte_idx    <= '0;
         cross_ready <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         case (phase)
            FR_IDLE: begin
               if (capture) begin
                  word_q      <= ascii_out;
                  byte_idx    <= '0;
                  cross_ready <= 1'b0;
                  busy        <= 1'b1;
                  phase       <= FR_SEND;
               end
            end
            FR_SEND: begin
               if (byte_done) begin
                  if (byte_idx == LAST_IDX) begin
                     frame_done <= 1'b1;
                     phase      <= FR_DONE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                  end
               end
            end
            FR_DONE: begin
               frame_done  <= 1'b0;
               busy        <= 1'b0;
               cross_ready <= 1'b1;
               phase       <= FR_IDLE;
            end
            default: begin
               frame_done  <= 1'b0;
               busy        <= 1'b0;
               cross_ready <= 1'b1;
               phase       <= FR_IDLE;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clk       (clk),
      .rst       (rst),
      .start     (byte_start),
      .data      (byte_data),
      .tx        (tx),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx: one instance with CR LF, one digits-only.
module tb_ascii_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ascii_c, ascii_d;
   logic        bcd_c, bcd_d;
   logic        cross_c, tx_c, busy_c, fd_c;
   logic        cross_d, tx_d, busy_d, fd_d;
   logic        sel_c;
   logic        cross_s, tx_s, busy_s, fd_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign cross_s = sel_c ? cross_c : cross_d;
   assign tx_s    = sel_c ? tx_c    : tx_d;
   assign busy_s  = sel_c ? busy_c  : busy_d;
   assign fd_s    = sel_c ? fd_c    : fd_d;

   ascii_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1)) dut_crlf (
      .clk         (clk),
      .rst         (rst),
      .ascii_out   (ascii_c),
      .bcd_ready   (bcd_c),
      .cross_ready (cross_c),
      .tx          (tx_c),
      .busy        (busy_c),
      .frame_done  (fd_c)
   );

   ascii_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(0)) dut_digits (
      .clk         (clk),
      .rst         (rst),
      .ascii_out   (ascii_d),
      .bcd_ready   (bcd_d),
      .cross_ready (cross_d),
      .tx          (tx_d),
      .busy        (busy_d),
      .frame_done  (fd_d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word to the selected instance; called just after a falling edge.
   task automatic offer(input logic use_crlf, input logic [31:0] w);
      sel_c = use_crlf;
      check("offer_cross_ready", cross_s, 1);
      if (use_crlf) begin
         ascii_c = w;
         bcd_c   = 1'b1;
      end else begin
         ascii_d = w;
         bcd_d   = 1'b1;
      end
   endtask

   // Follow one frame from the capture edge; checks the ideal waveform cycle by cycle.
   task automatic run_frame(input logic use_crlf, input logic [31:0] exp_word,
                            input logic hold, input logic [31:0] late_word);
      logic [7:0] bytes [6];
      logic [7:0] rx;
      logic       exp_tx;
      int n_cyc, b, k, p;
      int wave_err, cr_err, busy_err, fd_err;
      n_cyc = (use_crlf ? 6 : 4) * 10 * CPB;
      for (int j = 0; j < 4; j++) bytes[j] = exp_word[31-8*j -: 8];
      bytes[4] = 8'h0D;
      bytes[5] = 8'h0A;
      rx = 8'h00;
      wave_err = 0; cr_err = 0; busy_err = 0; fd_err = 0;
      sel_c = use_crlf;
      @(posedge clk);
      for (int i = 0; i < n_cyc; i++) begin
         @(negedge clk);
         if (i == 0 && !hold) begin
            if (use_crlf) bcd_c = 1'b0; else bcd_d = 1'b0;
         end
         if (hold && i == 20) begin
            if (use_crlf) ascii_c = late_word; else ascii_d = late_word;
         end
         b = i / CPB;
         k = b / 10;
         p = b % 10;
         if (p == 0)      exp_tx = 1'b0;
         else if (p == 9) exp_tx = 1'b1;
         else             exp_tx = bytes[k][p-1];
         if (tx_s !== exp_tx) wave_err++;
         if (p >= 1 && p <= 8 && (i % CPB) == CPB/2) rx[p-1] = tx_s;
         if (p == 9 && (i % CPB) == CPB/2) check($sformatf("byte%0d", k), rx, bytes[k]);
         if (cross_s !== 1'b0) cr_err++;
         if (busy_s  !== 1'b1) busy_err++;
         if (fd_s    !== 1'b0) fd_err++;
      end
      check("bit_timing_waveform", wave_err, 0);
      check("cross_ready_low_in_frame", cr_err, 0);
      check("busy_high_in_frame", busy_err, 0);
      check("frame_done_early", fd_err, 0);
      @(negedge clk);
      check("frame_done_pulse", fd_s, 1);
      check("done_cross_ready", cross_s, 0);
      check("done_busy", busy_s, 1);
      check("done_tx", tx_s, 1);
      @(negedge clk);
      check("after_done_frame_done", fd_s, 0);
      check("after_done_cross_ready", cross_s, 1);
      check("after_done_busy", busy_s, 0);
   endtask

   initial begin
      int idle_err;
      rst     = 1'b0;
      ascii_c = '0;
      ascii_d = '0;
      bcd_c   = 1'b0;
      bcd_d   = 1'b0;
      sel_c   = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", tx_c, 1);
      check("rst_cross_ready", cross_c, 1);
      check("rst_busy", busy_c, 0);
      check("rst_frame_done", fd_c, 0);
      check("rst_tx_digits", tx_d, 1);
      rst = 1'b1;

      // Idle line for 100 cycles
      idle_err = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_c !== 1'b1 || busy_c !== 1'b0 || fd_c !== 1'b0) idle_err++;
         if (tx_d !== 1'b1 || busy_d !== 1'b0 || fd_d !== 1'b0) idle_err++;
      end
      check("idle_line", idle_err, 0);

      // Basic frame with CR LF: "0243"
      offer(1'b1, 32'h30323433);
      run_frame(1'b1, 32'h30323433, 1'b0, 32'h0);

      // Digits only: "0011"
      @(negedge clk);
      offer(1'b0, 32'h30303131);
      run_frame(1'b0, 32'h30303131, 1'b0, 32'h0);

      // bcd_ready held and data changed mid-frame; the next word is taken once ready returns
      @(negedge clk);
      offer(1'b1, 32'h31323334);
      run_frame(1'b1, 32'h31323334, 1'b1, 32'h39393939);
      run_frame(1'b1, 32'h39393939, 1'b0, 32'h0);

      // Reset during DATA of byte 2 (0x37, bit 3 = 0 at cycle 97)
      @(negedge clk);
      offer(1'b1, 32'h35363738);
      @(posedge clk);
      for (int i = 0; i < 98; i++) begin
         @(negedge clk);
         if (i == 0) bcd_c = 1'b0;
      end
      check("pre_reset_tx_low", tx_c, 0);
      check("pre_reset_busy", busy_c, 1);
      rst = 1'b0;
      #1;
      check("midrst_tx", tx_c, 1);
      check("midrst_busy", busy_c, 0);
      check("midrst_cross_ready", cross_c, 1);
      check("midrst_frame_done", fd_c, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      offer(1'b1, 32'h31393837);
      run_frame(1'b1, 32'h31393837, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
